dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (port "cpu") and a secondary master such as a debug/DMA bridge (port "dev").
- Sequences every access through a 3-state FSM and drives the DM address, data, write-enable, access-size and stall inputs.
- Returns the raw memory word, an alignment error flag and a one-cycle ack to the winning requester.
- Drives a stall to the CPU pipeline while the CPU request is pending.

Parameters:
- ADDR_W, 32, requester/DM address width.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  single system clock; all state updates on posedge clk.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held, with fields stable, until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  3  access size, one of L_S_B / L_S_H / L_S_W.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data, right-aligned.
- cpu_rdata  out  DATA_W  raw memory word; valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  misaligned access; valid with cpu_ack.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- dev_req, dev_we, dev_size, dev_addr, dev_wdata, dev_rdata, dev_ack, dev_err: same meaning for the dev port.
- dm_wr  out  1  DM write enable.
- dm_addr  out  ADDR_W  DM address.
- dm_din  out  DATA_W  DM write data.
- dm_lssl  out  3  DM access size.
- dm_stall  out  1  DM write inhibit.
- dm_dout  in  DATA_W  DM combinational read word.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Registers:
  - owner (CPU/DEV)
  - latched request fields: we, size, addr, wdata
  - misalign flag
  - rdata register
  - last_grant
- IDLE:
  - If no request, stay in IDLE.
  - If one request, grant it.
  - If both request, arbitrate (see Optional Feature).
  - On a grant: latch the winner's fields, set owner, compute misalign, go to ACCESS.
- misalign = (size==L_S_W & addr[1:0]!=0) | (size==L_S_H & addr[0]!=0).
- ACCESS:
  - Drive dm_addr, dm_din and dm_lssl from the latched fields.
  - dm_wr = we & ~misalign; dm_stall = misalign.
  - Capture dm_dout into rdata; go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle; its rdata and err are valid.
  - The other port's ack stays 0. Update last_grant = owner. Go to IDLE.
- Latency: request sampled in IDLE at cycle N; ack in cycle N+2. Minimum period between back-to-back accesses is 3 cycles.
- A requester holding req high after its ack is re-arbitrated in the next IDLE cycle. A requester dropping req in its ack cycle is legal.
- Outside ACCESS: dm_wr=0, dm_stall=1, dm_addr/dm_din/dm_lssl hold the latched values (no X).
- A request deasserted before ack is a protocol violation with undefined result; the bench flags it with an assertion.
- Only the ACCESS state can write; at most one DM write per transaction.
- Reset (any state, including mid-transaction):
  - Next state IDLE; no ack issued; dm_wr=0.
  - Both acks and errs 0; rdata registers 0; last_grant = DEV, so the CPU wins first.
- Reset outputs: cpu_ack=dev_ack=0, cpu_err=dev_err=0, cpu_rdata=dev_rdata=0, dm_wr=0, dm_stall=1, dm_addr=0, dm_din=0, dm_lssl=0.
- rdata is not sign/zero-extended; the requester extracts bytes using its own addr[1:0].

Optional Feature:
- Macro DM_ARB_RR_EN.
- Defined: round-robin. On simultaneous requests, the port that did not hold last_grant wins, so neither port waits more than one transaction.
- Undefined: fixed priority; CPU always wins. last_grant is still maintained but ignored by arbitration.

Decomposition:
- Shared package/header: L_S_B, L_S_H, L_S_W size codes (existing values), FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), OWNER_CPU/OWNER_DEV constants.
- One natural sub-module: dm_arb_pick. It is combinational: inputs cpu_req, dev_req, last_grant; outputs grant_valid and grant_owner. It contains the DM_ARB_RR_EN logic.

Test Plan:
- CPU word store alone, addr=0x10, data=0xDEADBEEF:
  - dm_wr=1 exactly one cycle with dm_addr=0x10 and dm_lssl=L_S_W.
  - cpu_ack 2 cycles after req; cpu_stall high for those 2 cycles.
  - A following load of 0x10 returns 0xDEADBEEF.
- Simultaneous cpu_req and dev_req held for 4 transactions:
  - RR_EN: grants CPU, DEV, CPU, DEV.
  - Without RR_EN: all 4 to CPU while cpu_req is held.
- Dev half store addr=0x13, size=L_S_H: dev_ack with dev_err=1, dm_wr stays 0, memory unchanged.
- Reset asserted in ACCESS during a CPU store: no cpu_ack; FSM in IDLE next cycle; all outputs at reset values.
- Back-to-back CPU loads with cpu_req held: acks spaced exactly 3 cycles apart; dev_ack never pulses.
- Byte store 0xAB to addr=0x21 (dev): dm_lssl=L_S_B, dm_addr=0x21; a subsequent word load of 0x20 shows byte 1 = 0xAB.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Size codes match the DM access-size encoding used by the CPU MEM stage.
package dm_arbiter_pkg;

   localparam int unsigned SIZE_W = 3;

   localparam logic [SIZE_W-1:0] L_S_B = 3'd1;
   localparam logic [SIZE_W-1:0] L_S_H = 3'd2;
   localparam logic [SIZE_W-1:0] L_S_W = 3'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DEV = 1'b1
   } owner_t;

   // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
   function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                          input logic [1:0]        a_lo);
      return ((size == L_S_W) && (a_lo != 2'b00)) ||
             ((size == L_S_H) && a_lo[0]);
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signal bundle for dm_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface dm_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   import dm_arbiter_pkg::*;

   logic              cpu_req;
   logic              cpu_we;
   logic [SIZE_W-1:0] cpu_size;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_err;
   logic              cpu_stall;

   logic              dev_req;
   logic              dev_we;
   logic [SIZE_W-1:0] dev_size;
   logic [ADDR_W-1:0] dev_addr;
   logic [DATA_W-1:0] dev_wdata;
   logic [DATA_W-1:0] dev_rdata;
   logic              dev_ack;
   logic              dev_err;
   logic              dev_stall;

   logic              dm_wr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_din;
   logic [SIZE_W-1:0] dm_lssl;
   logic              dm_stall;
   logic [DATA_W-1:0] dm_dout;

   modport master (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
      input  dev_req, dev_we, dev_size, dev_addr, dev_wdata,
      output dev_rdata, dev_ack, dev_err, dev_stall,
      output dm_wr, dm_addr, dm_din, dm_lssl, dm_stall,
      input  dm_dout
   );

   modport slave (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
      output dev_req, dev_we, dev_size, dev_addr, dev_wdata,
      input  dev_rdata, dev_ack, dev_err, dev_stall,
      input  dm_wr, dm_addr, dm_din, dm_lssl, dm_stall,
      output dm_dout
   );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational grant selection between the cpu and dev requesters.
// DM_ARB_RR_EN selects round-robin on collisions; otherwise the CPU always wins.
module dm_arb_pick
   import dm_arbiter_pkg::*;
(
   input  logic   cpu_req,
   input  logic   dev_req,
   input  owner_t last_grant,
   output logic   grant_valid,
   output owner_t grant_owner
);

`ifdef DM_ARB_RR_EN
   always_comb begin
      grant_valid = cpu_req | dev_req;
      grant_owner = OWNER_CPU;
      if (cpu_req && dev_req) begin
         grant_owner = (last_grant == OWNER_CPU) ? OWNER_DEV : OWNER_CPU;
      end else if (dev_req) begin
         grant_owner = OWNER_DEV;
      end
   end
`else
   // last_grant is not consulted under fixed priority.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant_valid = cpu_req | dev_req;
      grant_owner = OWNER_CPU;
      if (!cpu_req && dev_req) begin
         grant_owner = OWNER_DEV;
      end
   end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a dev master.
// Arbitration policy set by DM_ARB_RR_EN (see dm_arb_pick); default is CPU priority.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input logic          clk,
   input logic          Reset,
   dm_arbiter_if.master bus
);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_grant_q, last_grant_d;
   owner_t            grant_owner;
   logic              grant_valid;
   logic              we_q, we_d;
   logic              mis_q, mis_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dev_rdata_q, dev_rdata_d;
   logic              cpu_ack_q, cpu_ack_d, dev_ack_q, dev_ack_d;
   logic              cpu_err_q, cpu_err_d, dev_err_q, dev_err_d;
   logic              dm_wr_q, dm_wr_d, dm_stall_q, dm_stall_d;

   dm_arb_pick u_pick (
      .cpu_req     (bus.cpu_req),
      .dev_req     (bus.dev_req),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         owner_q      <= OWNER_CPU;
         last_grant_q <= OWNER_DEV;
         we_q         <= 1'b0;
         mis_q        <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         dev_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dev_ack_q    <= 1'b0;
         cpu_err_q    <= 1'b0;
         dev_err_q    <= 1'b0;
         dm_wr_q      <= 1'b0;
         dm_stall_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         mis_q        <= mis_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dev_rdata_q  <= dev_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dev_ack_q    <= dev_ack_d;
         cpu_err_q    <= cpu_err_d;
         dev_err_q    <= dev_err_d;
         dm_wr_q      <= dm_wr_d;
         dm_stall_q   <= dm_stall_d;
      end
   end

   // DM strobes are computed one state early so they come straight from flops in ACCESS.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      mis_d        = mis_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dev_rdata_d  = dev_rdata_q;
      cpu_ack_d    = 1'b0;
      dev_ack_d    = 1'b0;
      cpu_err_d    = 1'b0;
      dev_err_d    = 1'b0;
      dm_wr_d      = 1'b0;
      dm_stall_d   = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_owner;
               if (grant_owner == OWNER_CPU) begin
                  we_d    = bus.cpu_we;
                  size_d  = bus.cpu_size;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
               end else begin
                  we_d    = bus.dev_we;
                  size_d  = bus.dev_size;
                  addr_d  = bus.dev_addr;
                  wdata_d = bus.dev_wdata;
               end
               mis_d      = is_misaligned(size_d, addr_d[1:0]);
               dm_wr_d    = we_d & ~mis_d;
               dm_stall_d = mis_d;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (owner_q == OWNER_CPU) begin
               cpu_ack_d   = 1'b1;
               cpu_err_d   = mis_q;
               cpu_rdata_d = bus.dm_dout;
            end else begin
               dev_ack_d   = 1'b1;
               dev_err_d   = mis_q;
               dev_rdata_d = bus.dm_dout;
            end
            state_d = RESP;
         end
         RESP: begin
            last_grant_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
   assign bus.dev_rdata = dev_rdata_q;
   assign bus.dev_ack   = dev_ack_q;
   assign bus.dev_err   = dev_err_q;
   assign bus.dev_stall = bus.dev_req & ~dev_ack_q;

   // A reset landing in ACCESS must suppress the write already staged in dm_wr_q.
   assign bus.dm_wr    = dm_wr_q & ~Reset;
   assign bus.dm_addr  = addr_q;
   assign bus.dm_din   = wdata_q;
   assign bus.dm_lssl  = size_q;
   assign bus.dm_stall = dm_stall_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant cycle + 2 = ack, next grant no earlier than +3).
module tb_dm_arbiter;
   import dm_arbiter_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .Reset(Reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] env_mem [64];
   logic [31:0] mdl_mem [64];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] size,
                                         input logic [1:0] lo, input logic [31:0] wd);
      logic [31:0] r;
      r = old;
      if (size == L_S_B)      r[{lo, 3'b000} +: 8] = wd[7:0];
      else if (size == L_S_H) r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      else                    r = wd;
      return r;
   endfunction

   // Memory the DUT talks to: combinational read, write on the clock edge.
   assign bus.dm_dout = env_mem[bus.dm_addr[7:2]];
   always @(posedge clk)
      if (bus.dm_wr)
         env_mem[bus.dm_addr[7:2]] <= merge(env_mem[bus.dm_addr[7:2]], bus.dm_lssl,
                                            bus.dm_addr[1:0], bus.dm_din);

   assert property (@(posedge clk) (!Reset && bus.cpu_req && !bus.cpu_ack) |=> (bus.cpu_req || Reset))
      else $error("protocol: cpu_req dropped before cpu_ack");
   assert property (@(posedge clk) (!Reset && bus.dev_req && !bus.dev_ack) |=> (bus.dev_req || Reset))
      else $error("protocol: dev_req dropped before dev_ack");

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model state: one outstanding transaction at most.
   bit          p_valid = 1'b0, p_dev, p_we, p_err, last_dev = 1'b1;
   logic [2:0]  p_size;
   logic [31:0] p_addr, p_wdata, p_rdata;
   int          p_gcyc = 0, free_cyc = 0;

   // Observations of the cycle just checked.
   bit          obs_cpu_ack, obs_dev_ack, obs_cpu_err, obs_dev_err;
   logic [31:0] obs_cpu_rdata, obs_dev_rdata;
   bit          ack_dev[$];
   int          ack_at[$];
   int          wr_cnt = 0;
   logic [31:0] wr_addr;
   logic [2:0]  wr_lssl;

   task automatic model_step();
      bit acc, ack_now, e_cpu_ack, e_dev_ack, e_wr, win_dev;
      acc       = p_valid && (cyc == p_gcyc + 1);
      ack_now   = p_valid && (cyc == p_gcyc + 2);
      e_cpu_ack = ack_now && !p_dev;
      e_dev_ack = ack_now && p_dev;
      e_wr      = acc && p_we && !p_err && !Reset;

      chk1("cpu_ack", bus.cpu_ack, e_cpu_ack);
      chk1("dev_ack", bus.dev_ack, e_dev_ack);
      chk1("cpu_stall", bus.cpu_stall, bus.cpu_req & ~e_cpu_ack);
      chk1("dev_stall", bus.dev_stall, bus.dev_req & ~e_dev_ack);
      chk1("dm_wr", bus.dm_wr, e_wr);
      if (acc) begin
         chk32("dm_addr", bus.dm_addr, p_addr);
         chk32("dm_lssl", 32'(bus.dm_lssl), 32'(p_size));
         chk1("dm_stall", bus.dm_stall, p_err);
         if (p_we) chk32("dm_din", bus.dm_din, p_wdata);
      end else begin
         chk1("dm_stall_idle", bus.dm_stall, 1'b1);
      end
      if (e_cpu_ack) begin
         chk32("cpu_rdata", bus.cpu_rdata, p_rdata);
         chk1("cpu_err", bus.cpu_err, p_err);
      end
      if (e_dev_ack) begin
         chk32("dev_rdata", bus.dev_rdata, p_rdata);
         chk1("dev_err", bus.dev_err, p_err);
      end

      obs_cpu_ack = bus.cpu_ack;  obs_dev_ack = bus.dev_ack;
      obs_cpu_err = bus.cpu_err;  obs_dev_err = bus.dev_err;
      obs_cpu_rdata = bus.cpu_rdata;  obs_dev_rdata = bus.dev_rdata;
      if (bus.cpu_ack) begin ack_dev.push_back(1'b0); ack_at.push_back(cyc); end
      if (bus.dev_ack) begin ack_dev.push_back(1'b1); ack_at.push_back(cyc); end
      if (bus.dm_wr) begin wr_cnt++; wr_addr = bus.dm_addr; wr_lssl = bus.dm_lssl; end

      if (Reset) begin
         p_valid = 1'b0; last_dev = 1'b1; free_cyc = cyc + 1;
         return;
      end
      if (e_wr) mdl_mem[p_addr[7:2]] = merge(mdl_mem[p_addr[7:2]], p_size, p_addr[1:0], p_wdata);
      if (ack_now) begin last_dev = p_dev; p_valid = 1'b0; end
      if (!p_valid && cyc >= free_cyc && (bus.cpu_req || bus.dev_req)) begin
         if (bus.cpu_req && bus.dev_req) begin
`ifdef DM_ARB_RR_EN
            win_dev = !last_dev;
`else
            win_dev = 1'b0;
`endif
         end else begin
            win_dev = bus.dev_req;
         end
         p_dev   = win_dev;
         p_we    = win_dev ? bus.dev_we : bus.cpu_we;
         p_size  = win_dev ? bus.dev_size : bus.cpu_size;
         p_addr  = win_dev ? bus.dev_addr : bus.cpu_addr;
         p_wdata = win_dev ? bus.dev_wdata : bus.cpu_wdata;
         p_err   = (p_size == L_S_W && p_addr[1:0] != 2'b00) || (p_size == L_S_H && p_addr[0]);
         p_rdata = mdl_mem[p_addr[7:2]];
         p_gcyc  = cyc;
         free_cyc = cyc + 3;
         p_valid = 1'b1;
      end
   endtask

   task automatic end_cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_size = sz; bus.cpu_addr = a; bus.cpu_wdata = wd;
   endtask

   task automatic set_dev(input logic req, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
      bus.dev_req = req; bus.dev_we = we; bus.dev_size = sz; bus.dev_addr = a; bus.dev_wdata = wd;
   endtask

   task automatic rand_fields(output logic we, output logic [2:0] sz,
                              output logic [31:0] a, output logic [31:0] wd);
      int k;
      we = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 2));
      sz = (k == 0) ? L_S_B : (k == 1) ? L_S_H : L_S_W;
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = (sz == L_S_W) ? (a & 32'hFC) : (sz == L_S_H) ? (a & 32'hFE) : a;
      wd = $urandom;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      bus.cpu_req = 1'b0; bus.dev_req = 1'b0;
      end_cycle();
      Reset = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk1({tag, "_cpu_ack"}, bus.cpu_ack, 1'b0);
      chk1({tag, "_dev_ack"}, bus.dev_ack, 1'b0);
      chk1({tag, "_cpu_err"}, bus.cpu_err, 1'b0);
      chk1({tag, "_dev_err"}, bus.dev_err, 1'b0);
      chk32({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'h0);
      chk32({tag, "_dev_rdata"}, bus.dev_rdata, 32'h0);
      chk1({tag, "_dm_wr"}, bus.dm_wr, 1'b0);
      chk1({tag, "_dm_stall"}, bus.dm_stall, 1'b1);
      chk32({tag, "_dm_addr"}, bus.dm_addr, 32'h0);
      chk32({tag, "_dm_din"}, bus.dm_din, 32'h0);
      chk32({tag, "_dm_lssl"}, 32'(bus.dm_lssl), 32'h0);
   endtask

   // One complete transaction on a single port; returns rdata, err and ack latency.
   task automatic run_txn(input bit dev, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
      int  start;
      bit  done;
      start = cyc; done = 1'b0; rd = '0; er = 1'b0; lat = -1;
      if (dev) set_dev(1'b1, we, sz, a, wd); else set_cpu(1'b1, we, sz, a, wd);
      for (int k = 0; k < 10 && !done; k++) begin
         end_cycle();
         if (dev ? obs_dev_ack : obs_cpu_ack) begin
            done = 1'b1;
            lat  = cyc - 1 - start;
            rd   = dev ? obs_dev_rdata : obs_cpu_rdata;
            er   = dev ? obs_dev_err : obs_cpu_err;
         end
      end
      if (dev) bus.dev_req = 1'b0; else bus.cpu_req = 1'b0;
      chk1("txn_ack_seen", done, 1'b1);
   endtask

   // Keeps pending requests up until acked, then drops them.
   task automatic wait_release();
      for (int k = 0; k < 20 && (bus.cpu_req || bus.dev_req); k++) begin
         end_cycle();
         if (obs_cpu_ack) bus.cpu_req = 1'b0;
         if (obs_dev_ack) bus.dev_req = 1'b0;
      end
      chk1("release_done", bus.cpu_req | bus.dev_req, 1'b0);
   endtask

   initial begin
      logic [31:0] rd, a, wd;
      logic        er, we;
      logic [2:0]  sz;
      int          lat, w0, n;

      for (int i = 0; i < 64; i++) begin env_mem[i] = '0; mdl_mem[i] = '0; end
      Reset = 1'b1;
      set_cpu(1'b0, 1'b0, L_S_W, 32'h0, 32'h0);
      set_dev(1'b0, 1'b0, L_S_W, 32'h0, 32'h0);
      @(posedge clk); #1;
      end_cycle();
      end_cycle();
      Reset = 1'b0;
      check_reset_values("rst");

      // CPU word store, then reload.
      w0 = wr_cnt;
      run_txn(1'b0, 1'b1, L_S_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
      chk32("st_latency", 32'(lat), 32'd2);
      chk32("st_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk32("st_wr_addr", wr_addr, 32'h10);
      chk32("st_wr_lssl", 32'(wr_lssl), 32'(L_S_W));
      run_txn(1'b0, 1'b0, L_S_W, 32'h10, 32'h0, rd, er, lat);
      chk32("ld_rdata", rd, 32'hDEADBEEF);
      chk1("ld_err", er, 1'b0);

      // Misaligned dev halfword store: error, no write.
      w0 = wr_cnt;
      run_txn(1'b1, 1'b1, L_S_H, 32'h13, 32'h00005555, rd, er, lat);
      chk1("mis_err", er, 1'b1);
      chk32("mis_wr_count", 32'(wr_cnt - w0), 32'd0);
      run_txn(1'b0, 1'b0, L_S_W, 32'h10, 32'h0, rd, er, lat);
      chk32("mis_mem_kept", rd, 32'hDEADBEEF);

      // Dev byte store and word reload.
      run_txn(1'b1, 1'b1, L_S_B, 32'h21, 32'h000000AB, rd, er, lat);
      chk32("byte_wr_addr", wr_addr, 32'h21);
      chk32("byte_wr_lssl", 32'(wr_lssl), 32'(L_S_B));
      run_txn(1'b0, 1'b0, L_S_W, 32'h20, 32'h0, rd, er, lat);
      chk32("byte_lane1", 32'(rd[15:8]), 32'hAB);
      chk32("byte_word", rd, 32'h0000AB00);

      // Reset while the store is in ACCESS.
      w0 = wr_cnt;
      n  = ack_dev.size();
      set_cpu(1'b1, 1'b1, L_S_W, 32'h30, 32'h12345678);
      end_cycle();
      Reset = 1'b1; bus.cpu_req = 1'b0;
      end_cycle();
      Reset = 1'b0;
      check_reset_values("midrst");
      end_cycle();
      end_cycle();
      chk32("midrst_no_ack", 32'(ack_dev.size() - n), 32'd0);
      chk32("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
      run_txn(1'b0, 1'b0, L_S_W, 32'h30, 32'h0, rd, er, lat);
      chk32("midrst_mem", rd, 32'h0);
      chk32("midrst_idle_latency", 32'(lat), 32'd2);

      // Both ports request continuously.
      do_reset();
      ack_dev.delete(); ack_at.delete();
      set_cpu(1'b1, 1'b0, L_S_W, 32'h10, 32'h0);
      set_dev(1'b1, 1'b0, L_S_W, 32'h20, 32'h0);
      for (int g = 0; g < 40 && ack_dev.size() < 4; g++) end_cycle();
      chk1("both_four_acks", ack_dev.size() >= 4, 1'b1);
      if (obs_cpu_ack) bus.cpu_req = 1'b0;
      if (obs_dev_ack) bus.dev_req = 1'b0;
      wait_release();
      for (int i = 0; i < 4; i++) begin
         if (ack_dev.size() > i) begin
`ifdef DM_ARB_RR_EN
            chk1($sformatf("grant%0d", i), ack_dev[i], (i % 2) == 1);
`else
            chk1($sformatf("grant%0d", i), ack_dev[i], 1'b0);
`endif
         end
      end

      // Back-to-back CPU loads with req held.
      ack_dev.delete(); ack_at.delete();
      set_cpu(1'b1, 1'b0, L_S_W, 32'h10, 32'h0);
      for (int g = 0; g < 30 && ack_dev.size() < 4; g++) end_cycle();
      bus.cpu_req = 1'b0;
      chk32("b2b_acks", 32'(ack_dev.size()), 32'd4);
      n = 0;
      for (int i = 0; i < ack_dev.size(); i++) if (ack_dev[i]) n++;
      chk32("b2b_dev_acks", 32'(n), 32'd0);
      for (int i = 1; i < ack_at.size(); i++)
         chk32($sformatf("b2b_gap%0d", i), 32'(ack_at[i] - ack_at[i-1]), 32'd3);

      // Random traffic, including occasional resets.
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 299) == 0) begin
            Reset = 1'b1; bus.cpu_req = 1'b0; bus.dev_req = 1'b0;
         end else begin
            Reset = 1'b0;
            if (obs_cpu_ack || !bus.cpu_req) begin
               rand_fields(we, sz, a, wd);
               set_cpu(1'($urandom_range(0, 2) == 0), we, sz, a, wd);
            end
            if (obs_dev_ack || !bus.dev_req) begin
               rand_fields(we, sz, a, wd);
               set_dev(1'($urandom_range(0, 2) == 0), we, sz, a, wd);
            end
         end
         end_cycle();
      end
      Reset = 1'b0;
      if (obs_cpu_ack) bus.cpu_req = 1'b0;
      if (obs_dev_ack) bus.dev_req = 1'b0;
      wait_release();
      end_cycle();
      end_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
